mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter for I-cache block fetches and LSB loads/stores.
// Optional IO_STALL_EN holds stores to the UART addresses while io_buffer_full is high.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1
) (
  input  logic                          Sys_clk,
  input  logic                          Sys_rst,
  input  logic                          Sys_rdy,
  input  logic [7:0]                    mem_din,
  output logic [7:0]                    mem_dout,
  output logic [ADDR_WIDTH-1:0]         mem_a,
  output logic                          mem_wr,
  input  logic                          io_buffer_full,
  input  logic                          ICMC_en,
  input  logic [ADDR_WIDTH-1:0]         ICMC_addr,
  output logic                          MCIC_en,
  output logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block,
  input  logic                          LSBMC_en,
  input  logic                          LSBMC_wr,
  input  logic [1:0]                    LSBMC_size,
  input  logic [ADDR_WIDTH-1:0]         LSBMC_addr,
  input  logic [31:0]                   LSBMC_data,
  output logic                          MCLSB_en,
  output logic [31:0]                   MCLSB_data,
  input  logic                          RoBMC_clear
);

  localparam int IC_BYTES = 4 << BLOCK_WIDTH;
  localparam int CNT_W    = $clog2(IC_BYTES + 2);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             idx;
  logic [CNT_W-1:0]             n_bytes;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [1:0]                   size_q;
  logic [31:0]                  data_q;
  logic [1:0]                   starve_q;
  logic                         ic_done_q;
  logic                         ls_done_q;
  logic [(32<<BLOCK_WIDTH)-1:0] block_q;
  logic [31:0]                  ld_q;
  logic                         in_window;
  logic                         last;
  logic                         stall;
  logic                         finish;
  logic                         grant;

  // cnt_q counts active edges since the grant; byte cnt_q-1 is on the bus.
  always_comb begin
    n_bytes = CNT_W'(4);
    if (state_q == IFETCH) begin
      n_bytes = CNT_W'(IC_BYTES);
    end else begin
      case (size_q)
        2'b00:   n_bytes = CNT_W'(1);
        2'b01:   n_bytes = CNT_W'(2);
        default: n_bytes = CNT_W'(4);
      endcase
    end
  end

  assign idx       = cnt_q - CNT_W'(1);
  assign in_window = (state_q != IDLE) && (cnt_q != '0) && (cnt_q <= n_bytes);
  assign last      = (cnt_q == n_bytes);

`ifdef IO_STALL_EN
  assign stall = (state_q == STORE) && io_buffer_full &&
                 ((addr_q == ADDR_WIDTH'(32'h30000)) || (addr_q == ADDR_WIDTH'(32'h30004)));
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        // No grant while a done pulse is out: the requester has not dropped en yet.
        if (!ic_done_q && !ls_done_q) begin
          if (ICMC_en && (starve_q == 2'd2))     state_d = IFETCH;
          else if (LSBMC_en && LSBMC_wr)         state_d = STORE;
          else if (LSBMC_en && !RoBMC_clear)     state_d = LOAD;
          else if (ICMC_en)                      state_d = IFETCH;
        end
      end
      IFETCH: begin
        if (last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      LOAD: begin
        if (RoBMC_clear) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      STORE: begin
        if (last && !stall) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      data_q    <= '0;
      starve_q  <= '0;
      ic_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      block_q   <= '0;
      ld_q      <= '0;
    end else if (Sys_rdy) begin
      state_q   <= state_d;
      ic_done_q <= finish && (state_q == IFETCH);
      ls_done_q <= finish && (state_q != IFETCH);
      if (grant) begin
        cnt_q <= '0;
        if (state_d == IFETCH) begin
          addr_q   <= ICMC_addr;
          starve_q <= '0;
        end else begin
          addr_q   <= LSBMC_addr;
          size_q   <= LSBMC_size;
          data_q   <= LSBMC_data;
          // Saturates at 2 by construction: at 2 with ICMC_en high the next grant is IFETCH.
          starve_q <= ICMC_en ? starve_q + 2'd1 : 2'd0;
          if (state_d == LOAD) ld_q <= '0;
        end
      end else if ((state_q != IDLE) && !stall) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (in_window) begin
          if (state_q == IFETCH)    block_q[{idx, 3'b000} +: 8] <= mem_din;
          else if (state_q == LOAD) ld_q[{idx[1:0], 3'b000} +: 8] <= mem_din;
        end
      end
    end
  end

  assign mem_a      = in_window ? (addr_q + ADDR_WIDTH'(idx)) : '0;
  assign mem_wr     = Sys_rdy && (state_q == STORE) && in_window && !stall;
  assign mem_dout   = ((state_q == STORE) && in_window) ? data_q[{idx[1:0], 3'b000} +: 8] : 8'h00;
  assign MCIC_en    = ic_done_q && Sys_rdy;
  assign MCLSB_en   = ls_done_q && Sys_rdy;
  assign MCIC_block = block_q;
  assign MCLSB_data = ld_q;

endmodule
